// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT defaults, {re,im} pack helpers, clamp function and radix-8 twiddles
package fft_pkg;

  localparam int DW_DEF   = 12;
  localparam int TW_DEF   = 12;
  localparam int FRAC_DEF = 10;

  typedef logic signed [DW_DEF-1:0] data_t;
  typedef logic signed [TW_DEF-1:0] tw_t;

  typedef struct packed {
    tw_t re;
    tw_t im;
  } twiddle_t;

  // 1.0 == 1024 at FRAC=10; 724 ~= 1024/sqrt(2)
  localparam twiddle_t W8_0 = '{re: 12'sd1024,  im: 12'sd0};
  localparam twiddle_t W8_1 = '{re: 12'sd724,   im: -12'sd724};
  localparam twiddle_t W8_2 = '{re: 12'sd0,     im: -12'sd1024};
  localparam twiddle_t W8_3 = '{re: -12'sd724,  im: -12'sd724};

  function automatic logic [2*DW_DEF-1:0] cplx_pack(input data_t re, input data_t im);
    return {re, im};
  endfunction

  function automatic data_t cplx_re(input logic [2*DW_DEF-1:0] v);
    return data_t'(v[2*DW_DEF-1:DW_DEF]);
  endfunction

  function automatic data_t cplx_im(input logic [2*DW_DEF-1:0] v);
    return data_t'(v[DW_DEF-1:0]);
  endfunction

  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cplx_round_sat.sv
// rtl/cplx_round_sat.sv - combinational round-half-up / floor shift and optional clamp to DW bits
module cplx_round_sat
  import fft_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int TW       = TW_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int ROUND_EN = 1,
  parameter int SAT_EN   = 1
) (
  input  logic signed [DW+TW:0] acc,
  output logic [DW-1:0]         y,
  output logic                  sat
);

  localparam int AW = DW + TW + 1;
  // One guard bit so the rounding constant can never overflow the accumulator
  localparam int RW = AW + 1;
  localparam logic signed [RW-1:0] RND_K =
    (ROUND_EN != 0) ? (RW'(1) << (FRAC - 1)) : RW'(0);

  logic signed [RW-1:0] acc_ext;
  logic signed [RW-1:0] rounded;
  logic signed [RW-1:0] shifted;
  logic signed [63:0]   wide;
  logic signed [63:0]   clamped;

  always_comb begin
    acc_ext = {acc[AW-1], acc};
    rounded = acc_ext + RND_K;
    shifted = rounded >>> FRAC;
    wide    = {{(64-RW){shifted[RW-1]}}, shifted};
    clamped = sat_clamp(wide, DW);
    if (SAT_EN != 0) begin
      y   = clamped[DW-1:0];
      sat = (clamped != wide);
    end else begin
      y   = shifted[DW-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/twiddle_mult_pipe.sv
// rtl/twiddle_mult_pipe.sv - three-stage pipelined complex multiplier y = x*W or x*conj(W) with back-pressure
module twiddle_mult_pipe
  import fft_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int TW       = TW_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int ROUND_EN = 1,
  parameter int SAT_EN   = 1
) (
  input  logic            clk,
  input  logic            reset_p,
  input  logic            conj_mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] in_x,
  input  logic [2*TW-1:0] in_w,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_y,
  output logic [1:0]      out_sat,
  output logic            sat_sticky
);

  localparam int PW = DW + TW;
  localparam int AW = PW + 1;

  logic              v1_q, v1_d;
  logic [2*DW-1:0]   x_q, x_d;
  logic [2*TW-1:0]   w_q, w_d;
  logic              conj_q, conj_d;

  logic              v2_q, v2_d;
  logic signed [PW-1:0] p_rr_q, p_rr_d;
  logic signed [PW-1:0] p_ii_q, p_ii_d;
  logic signed [PW-1:0] p_ri_q, p_ri_d;
  logic signed [PW-1:0] p_ir_q, p_ir_d;

  logic              v3_q, v3_d;
  logic [2*DW-1:0]   y_q, y_d;
  logic [1:0]        sat_q, sat_d;
  logic              sticky_q, sticky_d;

  logic              stall;
  logic              advance;
  logic signed [PW-1:0] xr_e, xi_e, wr_e, wi_e;
  logic signed [PW-1:0] prod_rr, prod_ir, raw_ii, raw_ri;
  logic signed [AW-1:0] acc_re, acc_im;
  logic [DW-1:0]     y_re, y_im;
  logic              s_re, s_im;

  always_comb begin
    stall   = v3_q && !out_ready;
    advance = !stall;
    xr_e    = {{TW{x_q[2*DW-1]}}, x_q[2*DW-1:DW]};
    xi_e    = {{TW{x_q[DW-1]}}, x_q[DW-1:0]};
    wr_e    = {{DW{w_q[2*TW-1]}}, w_q[2*TW-1:TW]};
    wi_e    = {{DW{w_q[TW-1]}}, w_q[TW-1:0]};
    // True products fit in PW bits, so the low PW bits of the PW x PW product are exact
    prod_rr = xr_e * wr_e;
    prod_ir = xi_e * wr_e;
    raw_ii  = xi_e * wi_e;
    raw_ri  = xr_e * wi_e;
    acc_re  = {p_rr_q[PW-1], p_rr_q} - {p_ii_q[PW-1], p_ii_q};
    acc_im  = {p_ri_q[PW-1], p_ri_q} + {p_ir_q[PW-1], p_ir_q};
  end

  cplx_round_sat #(
    .DW(DW), .TW(TW), .FRAC(FRAC), .ROUND_EN(ROUND_EN), .SAT_EN(SAT_EN)
  ) u_rs_re (
    .acc (acc_re),
    .y   (y_re),
    .sat (s_re)
  );

  cplx_round_sat #(
    .DW(DW), .TW(TW), .FRAC(FRAC), .ROUND_EN(ROUND_EN), .SAT_EN(SAT_EN)
  ) u_rs_im (
    .acc (acc_im),
    .y   (y_im),
    .sat (s_im)
  );

  always_comb begin
    v1_d     = v1_q;
    x_d      = x_q;
    w_d      = w_q;
    conj_d   = conj_q;
    v2_d     = v2_q;
    p_rr_d   = p_rr_q;
    p_ii_d   = p_ii_q;
    p_ri_d   = p_ri_q;
    p_ir_d   = p_ir_q;
    v3_d     = v3_q;
    y_d      = y_q;
    sat_d    = sat_q;
    sticky_d = sticky_q | (v3_q && out_ready && (sat_q != 2'b00));

    // The whole pipe freezes together; bubbles are kept rather than squeezed out
    if (advance) begin
      v1_d = in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      if (in_valid) begin
        x_d    = in_x;
        w_d    = in_w;
        conj_d = conj_mode;
      end
      if (v1_q) begin
        p_rr_d = prod_rr;
        p_ir_d = prod_ir;
        // Conjugation negates in the product domain so -(-2**(TW-1)) stays exact
        p_ii_d = conj_q ? -raw_ii : raw_ii;
        p_ri_d = conj_q ? -raw_ri : raw_ri;
      end
      if (v2_q) begin
        y_d   = {y_re, y_im};
        sat_d = {s_re, s_im};
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      v1_q     <= 1'b0;
      x_q      <= '0;
      w_q      <= '0;
      conj_q   <= 1'b0;
      v2_q     <= 1'b0;
      p_rr_q   <= '0;
      p_ii_q   <= '0;
      p_ri_q   <= '0;
      p_ir_q   <= '0;
      v3_q     <= 1'b0;
      y_q      <= '0;
      sat_q    <= 2'b00;
      sticky_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      x_q      <= x_d;
      w_q      <= w_d;
      conj_q   <= conj_d;
      v2_q     <= v2_d;
      p_rr_q   <= p_rr_d;
      p_ii_q   <= p_ii_d;
      p_ri_q   <= p_ri_d;
      p_ir_q   <= p_ir_d;
      v3_q     <= v3_d;
      y_q      <= y_d;
      sat_q    <= sat_d;
      sticky_q <= sticky_d;
    end
  end

  assign in_ready   = !stall;
  assign out_valid  = v3_q;
  assign out_y      = y_q;
  assign out_sat    = sat_q;
  assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// tb/tb_twiddle_mult_pipe.sv - scoreboard bench for twiddle_mult_pipe (round/sat, floor, wrap variants)
module tb_twiddle_mult_pipe;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        reset_p = 1'b1;
  logic        conj_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] in_x = '0;
  logic [23:0] in_w = '0;

  logic        m_in_ready, m_out_valid, m_sticky;
  logic [23:0] m_out_y;
  logic [1:0]  m_out_sat;
  logic        t_in_ready, t_out_valid, t_sticky;
  logic [23:0] t_out_y;
  logic [1:0]  t_out_sat;
  logic        n_in_ready, n_out_valid, n_sticky;
  logic [23:0] n_out_y;
  logic [1:0]  n_out_sat;

  typedef struct packed {
    logic [23:0] y;
    logic [1:0]  sat;
  } exp_t;

  exp_t q_m[$];
  exp_t q_t[$];
  exp_t q_n[$];

  int checks = 0;
  int failures = 0;
  int n_out_m = 0;
  int stall_cycles = 0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_y = '0;
  logic [23:0] last_n_y = '0;
  logic [1:0]  last_n_sat = '0;

  twiddle_mult_pipe dut_m (
    .clk(clk), .reset_p(reset_p), .conj_mode(conj_mode), .in_valid(in_valid),
    .in_ready(m_in_ready), .in_x(in_x), .in_w(in_w), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_y(m_out_y), .out_sat(m_out_sat), .sat_sticky(m_sticky)
  );

  twiddle_mult_pipe #(.ROUND_EN(0)) dut_t (
    .clk(clk), .reset_p(reset_p), .conj_mode(conj_mode), .in_valid(in_valid),
    .in_ready(t_in_ready), .in_x(in_x), .in_w(in_w), .out_valid(t_out_valid),
    .out_ready(out_ready), .out_y(t_out_y), .out_sat(t_out_sat), .sat_sticky(t_sticky)
  );

  twiddle_mult_pipe #(.SAT_EN(0)) dut_n (
    .clk(clk), .reset_p(reset_p), .conj_mode(conj_mode), .in_valid(in_valid),
    .in_ready(n_in_ready), .in_x(in_x), .in_w(in_w), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_y(n_out_y), .out_sat(n_out_sat), .sat_sticky(n_sticky)
  );

  always #5 clk = ~clk;

  function automatic void comp(input longint v, input bit rnd, input bit sat_en,
                               output logic [11:0] y, output logic s);
    longint r;
    r = rnd ? v + 512 : v;
    r = r >>> 10;
    s = 1'b0;
    if (sat_en && r > 2047) begin
      y = 12'h7ff;
      s = 1'b1;
    end else if (sat_en && r < -2048) begin
      y = 12'h800;
      s = 1'b1;
    end else begin
      y = r[11:0];
    end
  endfunction

  function automatic exp_t model(input logic [23:0] x, input logic [23:0] w,
                                 input logic cj, input bit rnd, input bit sat_en);
    longint xr, xi, wr, wi;
    logic [11:0] yr, yi;
    logic s1, s0;
    exp_t e;
    xr = longint'($signed(x[23:12]));
    xi = longint'($signed(x[11:0]));
    wr = longint'($signed(w[23:12]));
    wi = longint'($signed(w[11:0]));
    if (cj) wi = -wi;
    comp(xr * wr - xi * wi, rnd, sat_en, yr, s1);
    comp(xr * wi + xi * wr, rnd, sat_en, yi, s0);
    e.y   = {yr, yi};
    e.sat = {s1, s0};
    return e;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Must be entered at posedge+#1; returns at posedge+#1 after the accepting edge
  task automatic send(input logic [23:0] x, input logic [23:0] w, input logic cj,
                      input exp_t e_main);
    int guard;
    guard = 0;
    in_x = x;
    in_w = w;
    conj_mode = cj;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (m_in_ready) break;
      guard++;
      if (guard > 200) break;
      @(posedge clk);
      #1;
    end
    if (guard > 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", m_in_ready, guard);
      in_valid = 1'b0;
    end else begin
      q_m.push_back(e_main);
      q_t.push_back(model(x, w, cj, 1'b0, 1'b1));
      q_n.push_back(model(x, w, cj, 1'b1, 1'b0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((q_m.size() != 0 || q_t.size() != 0 || q_n.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    sync();
    checks++;
    if (q_m.size() != 0 || q_t.size() != 0 || q_n.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: pending m=%0d t=%0d n=%0d, want 0", name,
               q_m.size(), q_t.size(), q_n.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_p) begin
        prev_stall = 1'b0;
      end else begin
        checks++;
        if (t_out_valid !== m_out_valid || n_out_valid !== m_out_valid ||
            t_in_ready !== m_in_ready || n_in_ready !== m_in_ready) begin
          failures++;
          $display("FAIL lockstep: valid m/t/n=%b%b%b ready m/t/n=%b%b%b, want equal",
                   m_out_valid, t_out_valid, n_out_valid, m_in_ready, t_in_ready, n_in_ready);
        end
        if (m_out_valid && !out_ready) begin
          stall_cycles++;
          checks++;
          if (m_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_in_ready: got %b want 0", m_in_ready);
          end
        end
        if (prev_stall) begin
          checks++;
          if (m_out_y !== prev_y || m_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: out_y=%h valid=%b, want %h valid=1", m_out_y, m_out_valid, prev_y);
          end
        end
        prev_stall = m_out_valid && !out_ready;
        prev_y = m_out_y;
        if (m_out_valid && out_ready) begin
          n_out_m++;
          checks++;
          if (q_m.size() == 0) begin
            failures++;
            $display("FAIL m_unexpected: out_y=%h, want no output", m_out_y);
          end else begin
            e = q_m.pop_front();
            if (m_out_y !== e.y || m_out_sat !== e.sat) begin
              failures++;
              $display("FAIL m_out: y=%h sat=%b, want y=%h sat=%b", m_out_y, m_out_sat, e.y, e.sat);
            end
          end
        end
        if (t_out_valid && out_ready) begin
          checks++;
          if (q_t.size() == 0) begin
            failures++;
            $display("FAIL t_unexpected: out_y=%h, want no output", t_out_y);
          end else begin
            e = q_t.pop_front();
            if (t_out_y !== e.y || t_out_sat !== e.sat) begin
              failures++;
              $display("FAIL t_out: y=%h sat=%b, want y=%h sat=%b", t_out_y, t_out_sat, e.y, e.sat);
            end
          end
        end
        if (n_out_valid && out_ready) begin
          last_n_y = n_out_y;
          last_n_sat = n_out_sat;
          checks++;
          if (q_n.size() == 0) begin
            failures++;
            $display("FAIL n_unexpected: out_y=%h, want no output", n_out_y);
          end else begin
            e = q_n.pop_front();
            if (n_out_y !== e.y || n_out_sat !== e.sat) begin
              failures++;
              $display("FAIL n_out: y=%h sat=%b, want y=%h sat=%b", n_out_y, n_out_sat, e.y, e.sat);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (m_out_valid !== 1'b0 || m_out_y !== 24'h0 || m_out_sat !== 2'b00 || m_sticky !== 1'b0 ||
        t_out_valid !== 1'b0 || n_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b y=%h sat=%b sticky=%b, want all 0",
               m_out_valid, m_out_y, m_out_sat, m_sticky);
    end
    sync();
    reset_p = 1'b0;
    @(negedge clk);
    checks++;
    if (m_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", m_in_ready);
    end
    sync();
  endtask

  task automatic check_latency(input string name);
    logic [2:0] seen;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen[i] = m_out_valid;
    end
    checks++;
    if (seen !== 3'b100) begin
      failures++;
      $display("FAIL %s_latency: out_valid at n+1..n+3 = %b%b%b, want 001", name, seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_identity();
    send(cplx_pack(12'sd100, -12'sd50), W8_0, 1'b0, exp_t'({cplx_pack(12'sd100, -12'sd50), 2'b00}));
    check_latency("identity");
    checks++;
    if (m_out_y !== cplx_pack(12'sd100, -12'sd50) || m_out_sat !== 2'b00) begin
      failures++;
      $display("FAIL identity_value: y=%h sat=%b, want %h sat=00", m_out_y, m_out_sat,
               cplx_pack(12'sd100, -12'sd50));
    end
    drain("identity");
  endtask

  task automatic test_rounding();
    send(cplx_pack(12'sd1000, 12'sd0), W8_1, 1'b0, exp_t'({cplx_pack(12'sd707, -12'sd707), 2'b00}));
    send(cplx_pack(-12'sd1000, 12'sd0), W8_1, 1'b0, exp_t'({cplx_pack(-12'sd707, 12'sd707), 2'b00}));
    drain("rounding");
  endtask

  task automatic test_saturation();
    send(cplx_pack(12'sd2047, 12'sd2047), {12'sd1024, 12'sd1024}, 1'b0,
         exp_t'({cplx_pack(12'sd0, 12'sd2047), 2'b01}));
    drain("saturation");
    checks++;
    if (m_sticky !== 1'b1 || t_sticky !== 1'b1 || n_sticky !== 1'b0) begin
      failures++;
      $display("FAIL sat_sticky: m/t/n=%b%b%b, want 110", m_sticky, t_sticky, n_sticky);
    end
    checks++;
    if (last_n_y !== cplx_pack(12'sd0, -12'sd2) || last_n_sat !== 2'b00) begin
      failures++;
      $display("FAIL wrap_value: y=%h sat=%b, want %h sat=00", last_n_y, last_n_sat,
               cplx_pack(12'sd0, -12'sd2));
    end
  endtask

  task automatic test_conj();
    logic [23:0] x;
    logic [23:0] w;
    x = cplx_pack(12'sd0, 12'sd1024);
    w = {12'sd0, 12'sd1024};
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        send(x, w, 1'b0, exp_t'({cplx_pack(-12'sd1024, 12'sd0), 2'b00}));
      else
        send(x, w, 1'b1, exp_t'({cplx_pack(12'sd1024, 12'sd0), 2'b00}));
    end
    drain("conj");
  endtask

  task automatic test_back_to_back();
    int outs0;
    int stalls0;
    twiddle_t tws[4];
    tws[0] = W8_0;
    tws[1] = W8_1;
    tws[2] = W8_2;
    tws[3] = W8_3;
    outs0 = n_out_m;
    stalls0 = stall_cycles;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [23:0] x;
          logic [23:0] w;
          logic cj;
          x = {12'($urandom_range(4095)), 12'($urandom_range(4095))};
          w = tws[$urandom_range(3)];
          cj = 1'($urandom_range(1));
          send(x, w, cj, model(x, w, cj, 1'b1, 1'b1));
        end
      end
      begin
        for (int c = 0; c < 14; c++) begin
          out_ready = !(c >= 4 && c <= 9);
          sync();
        end
        out_ready = 1'b1;
      end
    join
    drain("back_pressure");
    checks++;
    if (n_out_m - outs0 != 8) begin
      failures++;
      $display("FAIL bp_count: outputs=%0d want 8", n_out_m - outs0);
    end
    checks++;
    if (stall_cycles - stalls0 != 6) begin
      failures++;
      $display("FAIL bp_stall_cycles: got %0d want 6", stall_cycles - stalls0);
    end
  endtask

  task automatic test_reset_mid();
    logic stale;
    for (int i = 0; i < 3; i++)
      send(cplx_pack(12'(100 + i), 12'sd7), W8_3, 1'b0,
           model(cplx_pack(12'(100 + i), 12'sd7), W8_3, 1'b0, 1'b1, 1'b1));
    #1;
    checks++;
    if (m_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_inflight: out_valid=%b want 1", m_out_valid);
    end
    #1;
    reset_p = 1'b1;
    #1;
    checks++;
    if (m_out_valid !== 1'b0 || t_out_valid !== 1'b0 || n_out_valid !== 1'b0 || m_out_y !== 24'h0) begin
      failures++;
      $display("FAIL mid_async_reset: valid=%b y=%h, want valid=0 y=0", m_out_valid, m_out_y);
    end
    q_m.delete();
    q_t.delete();
    q_n.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_p = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      failures++;
      $display("FAIL mid_stale_output: out_valid seen=%b want 0", stale);
    end
    sync();
    send(cplx_pack(12'sd321, -12'sd123), W8_0, 1'b0, exp_t'({cplx_pack(12'sd321, -12'sd123), 2'b00}));
    check_latency("post_reset");
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rounding();
    test_saturation();
    test_conj();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
